// File: rtl/mips_wb_pkg.sv
// Shared types and helpers for the MIPS posted-write buffer.
package mips_wb_pkg;

  localparam int WB_DATA_W   = 32;
  localparam int WB_BE_W     = 4;
  // Word addresses are held zero-extended to a fixed width so the entry type can be shared.
  localparam int WB_WA_MAX_W = 62;

  typedef struct packed {
    logic [WB_WA_MAX_W-1:0] word_addr;
    logic [WB_DATA_W-1:0]   data;
    logic [WB_BE_W-1:0]     be;
    logic                   valid;
  } wb_entry_t;

  typedef enum logic {
    DRAIN_IDLE  = 1'b0,
    DRAIN_ISSUE = 1'b1
  } drain_state_t;

  function automatic int WB_PTR_W(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/mips_wb_lane_select.sv
// Youngest-match selector: scans slots from the oldest position up to tail-1 so the youngest match wins.
module mips_wb_lane_select
  import mips_wb_pkg::*;
#(
  parameter int  DEPTH = 4,
  localparam int IDX_W = WB_PTR_W(DEPTH) - 1
) (
  input  logic [DEPTH-1:0] match,
  input  logic [IDX_W-1:0] tail_idx,
  output logic             hit,
  output logic [IDX_W-1:0] sel
);

  always_comb begin
    logic [IDX_W-1:0] idx;
    hit = 1'b0;
    sel = '0;
    idx = '0;
    for (int k = DEPTH; k >= 1; k--) begin
      idx = tail_idx - IDX_W'(k);
      if (match[idx]) begin
        hit = 1'b1;
        sel = idx;
      end
    end
  end

endmodule

// File: rtl/mips_write_buffer.sv
// Posted-write buffer between the MIPS data port and an Avalon write slave, with
// byte-lane store merging and per-byte store-to-load forwarding.
module mips_write_buffer
  import mips_wb_pkg::*;
#(
  parameter int DEPTH    = 4,
  parameter int MERGE_EN = 1,
  parameter int ADDR_W   = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_valid,
  input  logic [ADDR_W-1:0]      wr_address,
  input  logic [31:0]            wr_data,
  input  logic [3:0]             wr_byteenable,
  output logic                   wr_ready,
  input  logic [ADDR_W-1:0]      lk_address,
  output logic [3:0]             lk_byteenable,
  output logic [31:0]            lk_data,
  output logic [ADDR_W-1:0]      mem_address,
  output logic                   mem_write,
  output logic [31:0]            mem_writedata,
  output logic [3:0]             mem_byteenable,
  input  logic                   waitrequest,
  output logic [$clog2(DEPTH):0] count,
  output logic                   empty
);

  localparam int PTR_W = WB_PTR_W(DEPTH);
  localparam int IDX_W = PTR_W - 1;
  localparam int WA_W  = ADDR_W - 2;

  wb_entry_t            ent [DEPTH];
  logic [PTR_W-1:0]     head, tail, head_n, tail_n;
  logic [IDX_W-1:0]     head_idx, tail_idx;
  drain_state_t         state, state_n;
  logic                 full, push, pop, alloc;
  logic                 merge_hit;
  logic [IDX_W-1:0]     merge_sel;
  logic [DEPTH-1:0]     merge_match;
  logic [31:0]          merge_data;
  logic [3:0]           merge_be;
  logic [WB_WA_MAX_W-1:0] wr_wa, lk_wa;
  logic                 unused_addr_lsbs;

  assign unused_addr_lsbs = ^{wr_address[1:0], lk_address[1:0]};

  assign wr_wa    = WB_WA_MAX_W'(wr_address[ADDR_W-1:2]);
  assign lk_wa    = WB_WA_MAX_W'(lk_address[ADDR_W-1:2]);
  assign head_idx = head[IDX_W-1:0];
  assign tail_idx = tail[IDX_W-1:0];
  assign full     = (head[PTR_W-1] != tail[PTR_W-1]) && (head_idx == tail_idx);

  // Store acceptance: merge into an existing entry, otherwise allocate at the tail.
  always_comb begin
    merge_match = '0;
    for (int i = 0; i < DEPTH; i++) begin
      merge_match[i] = (MERGE_EN != 0) && ent[i].valid && (ent[i].word_addr == wr_wa)
                       && !(mem_write && (IDX_W'(i) == head_idx));
    end
  end

  mips_wb_lane_select #(.DEPTH(DEPTH)) u_merge_sel (
    .match    (merge_match),
    .tail_idx (tail_idx),
    .hit      (merge_hit),
    .sel      (merge_sel)
  );

  always_comb begin
    merge_be   = ent[merge_sel].be | wr_byteenable;
    merge_data = ent[merge_sel].data;
    for (int b = 0; b < 4; b++) begin
      if (wr_byteenable[b]) merge_data[8*b +: 8] = wr_data[8*b +: 8];
    end
  end

  assign wr_ready = !full || merge_hit;
  assign push     = wr_valid && wr_ready;
  assign alloc    = push && !merge_hit;
  assign pop      = mem_write && !waitrequest;
  assign head_n   = head + PTR_W'(pop);
  assign tail_n   = tail + PTR_W'(alloc);

  // Entry storage: only the valid bits are reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) ent[i].valid <= 1'b0;
    end else begin
      if (pop) ent[head_idx].valid <= 1'b0;
      if (push && merge_hit) begin
        ent[merge_sel].data <= merge_data;
        ent[merge_sel].be   <= merge_be;
      end else if (alloc) begin
        ent[tail_idx] <= '{word_addr: wr_wa, data: wr_data, be: wr_byteenable, valid: 1'b1};
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      empty <= 1'b1;
    end else begin
      head  <= head_n;
      tail  <= tail_n;
      count <= tail_n - head_n;
      empty <= (tail_n == head_n) && (state_n == DRAIN_IDLE);
    end
  end

  // Drain sequencer: present the head, hold it through waitrequest, then idle one cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= DRAIN_IDLE;
    else      state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      DRAIN_IDLE:  if (count != '0) state_n = DRAIN_ISSUE;
      DRAIN_ISSUE: if (!waitrequest) state_n = DRAIN_IDLE;
      default:     state_n = DRAIN_IDLE;
    endcase
  end

  assign mem_write      = (state == DRAIN_ISSUE);
  assign mem_address    = {ent[head_idx].word_addr[WA_W-1:0], 2'b00};
  assign mem_writedata  = ent[head_idx].data;
  assign mem_byteenable = ent[head_idx].be;

  // Forwarding: each byte lane independently picks its youngest covering entry.
  for (genvar b = 0; b < 4; b++) begin : g_lane
    logic [DEPTH-1:0] lane_match;
    logic             lane_hit;
    logic [IDX_W-1:0] lane_sel;

    always_comb begin
      lane_match = '0;
      for (int i = 0; i < DEPTH; i++) begin
        lane_match[i] = ent[i].valid && ent[i].be[b] && (ent[i].word_addr == lk_wa);
      end
    end

    mips_wb_lane_select #(.DEPTH(DEPTH)) u_lane_sel (
      .match    (lane_match),
      .tail_idx (tail_idx),
      .hit      (lane_hit),
      .sel      (lane_sel)
    );

    assign lk_byteenable[b]  = lane_hit;
    assign lk_data[8*b +: 8] = lane_hit ? ent[lane_sel].data[8*b +: 8] : 8'h00;
  end

endmodule

// File: tb/tb_mips_write_buffer.sv
// Bench for mips_write_buffer: a merging and a strict-FIFO instance run side by side
// against a queue-based model and a byte-level memory image.
module tb_mips_write_buffer;

  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_valid;
  logic [31:0] wr_address, wr_data, lk_address;
  logic [3:0]  wr_byteenable;
  logic        waitrequest;

  logic          wr_ready_o    [2];
  logic [3:0]    lk_be_o       [2];
  logic [31:0]   lk_data_o     [2];
  logic [31:0]   mem_address_o [2];
  logic          mem_write_o   [2];
  logic [31:0]   mem_wdata_o   [2];
  logic [3:0]    mem_be_o      [2];
  logic [CW-1:0] count_o       [2];
  logic          empty_o       [2];

  always #5 clk = ~clk;

  mips_write_buffer #(.DEPTH(DEPTH), .MERGE_EN(1), .ADDR_W(32)) u_dut_merge (
    .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_address(wr_address), .wr_data(wr_data),
    .wr_byteenable(wr_byteenable), .wr_ready(wr_ready_o[0]), .lk_address(lk_address),
    .lk_byteenable(lk_be_o[0]), .lk_data(lk_data_o[0]), .mem_address(mem_address_o[0]),
    .mem_write(mem_write_o[0]), .mem_writedata(mem_wdata_o[0]), .mem_byteenable(mem_be_o[0]),
    .waitrequest(waitrequest), .count(count_o[0]), .empty(empty_o[0])
  );

  mips_write_buffer #(.DEPTH(DEPTH), .MERGE_EN(0), .ADDR_W(32)) u_dut_fifo (
    .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_address(wr_address), .wr_data(wr_data),
    .wr_byteenable(wr_byteenable), .wr_ready(wr_ready_o[1]), .lk_address(lk_address),
    .lk_byteenable(lk_be_o[1]), .lk_data(lk_data_o[1]), .mem_address(mem_address_o[1]),
    .mem_write(mem_write_o[1]), .mem_writedata(mem_wdata_o[1]), .mem_byteenable(mem_be_o[1]),
    .waitrequest(waitrequest), .count(count_o[1]), .empty(empty_o[1])
  );

  typedef struct packed {
    logic [29:0] wa;
    logic [31:0] data;
    logic [3:0]  be;
  } ent_t;

  ent_t       mq [2][$];
  bit         iss [2];
  bit         sv_push [2];
  bit         sv_pop [2];
  int         sv_mj [2];
  logic [7:0] mem_exp [longint];
  logic [7:0] mem_act [longint];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic longint mkey(input int d, input logic [31:0] addr);
    return (longint'(d) << 40) | longint'(addr);
  endfunction

  // Compare every DUT output with the model, and decide what happens at the coming edge.
  task automatic check_cycle();
    for (int d = 0; d < 2; d++) begin
      int         n;
      int         mj;
      bit         rdy;
      logic [3:0] ebe;
      logic [31:0] edat;
      n    = mq[d].size();
      mj   = -1;
      ebe  = '0;
      edat = '0;
      if (d == 0) begin
        for (int i = 0; i < n; i++)
          if (mq[d][i].wa == wr_address[31:2] && !(i == 0 && iss[d])) mj = i;
      end
      rdy = (n < DEPTH) || (mj >= 0);
      for (int i = 0; i < n; i++)
        for (int b = 0; b < 4; b++)
          if (mq[d][i].wa == lk_address[31:2] && mq[d][i].be[b]) begin
            ebe[b] = 1'b1;
            edat[8*b +: 8] = mq[d][i].data[8*b +: 8];
          end
      chk($sformatf("d%0d_wr_ready", d), 64'(wr_ready_o[d]), 64'(rdy));
      chk($sformatf("d%0d_count", d), 64'(count_o[d]), 64'(n));
      chk($sformatf("d%0d_empty", d), 64'(empty_o[d]), 64'((n == 0) && !iss[d]));
      chk($sformatf("d%0d_mem_write", d), 64'(mem_write_o[d]), 64'(iss[d]));
      chk($sformatf("d%0d_lk_be", d), 64'(lk_be_o[d]), 64'(ebe));
      chk($sformatf("d%0d_lk_data", d), 64'(lk_data_o[d]), 64'(edat));
      if (iss[d] && n > 0) begin
        chk($sformatf("d%0d_mem_addr", d), 64'(mem_address_o[d]), 64'({mq[d][0].wa, 2'b00}));
        chk($sformatf("d%0d_mem_data", d), 64'(mem_wdata_o[d]), 64'(mq[d][0].data));
        chk($sformatf("d%0d_mem_be", d), 64'(mem_be_o[d]), 64'(mq[d][0].be));
      end
      if (mem_write_o[d] && !waitrequest) begin
        for (int b = 0; b < 4; b++)
          if (mem_be_o[d][b]) mem_act[mkey(d, mem_address_o[d] + 32'(b))] = mem_wdata_o[d][8*b +: 8];
      end
      sv_push[d] = wr_valid && rdy;
      sv_pop[d]  = iss[d] && !waitrequest;
      sv_mj[d]   = mj;
    end
  endtask

  task automatic update_model();
    for (int d = 0; d < 2; d++) begin
      bit   nxt;
      ent_t e;
      nxt = iss[d] ? waitrequest : (mq[d].size() > 0);
      if (sv_push[d]) begin
        for (int b = 0; b < 4; b++)
          if (wr_byteenable[b])
            mem_exp[mkey(d, {wr_address[31:2], 2'b00} + 32'(b))] = wr_data[8*b +: 8];
      end
      if (sv_push[d] && sv_mj[d] >= 0) begin
        e = mq[d][sv_mj[d]];
        for (int b = 0; b < 4; b++)
          if (wr_byteenable[b]) e.data[8*b +: 8] = wr_data[8*b +: 8];
        e.be = e.be | wr_byteenable;
        mq[d][sv_mj[d]] = e;
      end
      if (sv_pop[d]) void'(mq[d].pop_front());
      if (sv_push[d] && sv_mj[d] < 0) begin
        e.wa   = wr_address[31:2];
        e.data = wr_data;
        e.be   = wr_byteenable;
        mq[d].push_back(e);
      end
      iss[d] = nxt;
    end
  endtask

  // Called at a falling edge with inputs already driven; returns at the next falling edge.
  task automatic step();
    #1;
    check_cycle();
    @(posedge clk);
    update_model();
    @(negedge clk);
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] dat, input logic [3:0] be);
    wr_valid      = 1'b1;
    wr_address    = a;
    wr_data       = dat;
    wr_byteenable = be;
    step();
    wr_valid      = 1'b0;
  endtask

  task automatic cmp_mem();
    foreach (mem_exp[k]) begin
      logic [8:0] a;
      a = mem_act.exists(k) ? {1'b1, mem_act[k]} : 9'h000;
      chk($sformatf("mem_%0h", k), 64'(a), 64'({1'b1, mem_exp[k]}));
    end
  endtask

  task automatic drain();
    bit done;
    done        = 1'b0;
    wr_valid    = 1'b0;
    waitrequest = 1'b0;
    for (int c = 0; c < 100 && !done; c++) begin
      step();
      done = (mq[0].size() == 0) && !iss[0] && (mq[1].size() == 0) && !iss[1];
    end
    if (!done) chk("drain_timeout", 64'(0), 64'(1));
    cmp_mem();
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    wr_valid = 1'b0; wr_address = '0; wr_data = '0; wr_byteenable = '0;
    lk_address = '0; waitrequest = 1'b1;
    #12;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("rst_d%0d_count", d), 64'(count_o[d]), 64'(0));
      chk($sformatf("rst_d%0d_empty", d), 64'(empty_o[d]), 64'(1));
      chk($sformatf("rst_d%0d_ready", d), 64'(wr_ready_o[d]), 64'(1));
      chk($sformatf("rst_d%0d_mem_write", d), 64'(mem_write_o[d]), 64'(0));
    end
    @(negedge clk);
    rst = 1'b1;

    // Fill with the bus stalled, then release.
    lk_address = 32'h1000;
    for (int i = 0; i < 4; i++) store(32'h1000 + 32'(4*i), 32'(i*i), 4'hF);
    wr_address = 32'h1010;
    step();
    #1;
    chk("t1_count", 64'(count_o[0]), 64'(4));
    chk("t1_ready", 64'(wr_ready_o[0]), 64'(0));
    chk("t1_mem_addr", 64'(mem_address_o[0]), 64'h1000);
    drain();
    chk("t1_empty0", 64'(empty_o[0]), 64'(1));
    chk("t1_empty1", 64'(empty_o[1]), 64'(1));

    // Merge into a non-issued entry.
    waitrequest = 1'b1;
    store(32'h2000, 32'h0000_00AA, 4'b0001);
    store(32'h2004, 32'h0000_00CC, 4'b0001);
    store(32'h2004, 32'h00BB_0000, 4'b0100);
    lk_address = 32'h2004;
    #1;
    chk("t2_count_merge", 64'(count_o[0]), 64'(2));
    chk("t2_count_fifo", 64'(count_o[1]), 64'(3));
    chk("t2_lk_be", 64'(lk_be_o[0]), 64'(4'b0101));
    chk("t2_lk_data", 64'(lk_data_o[0]), 64'h00BB_00CC);
    drain();

    // Youngest wins per lane.
    waitrequest = 1'b1;
    store(32'h3000, 32'h0011_0022, 4'b0101);
    store(32'h3000, 32'h0000_3344, 4'b0011);
    lk_address = 32'h3000;
    #1;
    chk("t3_lk_data", 64'(lk_data_o[1]), 64'h0011_3344);
    chk("t3_lk_be", 64'(lk_be_o[1]), 64'(4'b0111));
    drain();

    // Push refused in the cycle the full buffer pops.
    waitrequest = 1'b1;
    for (int i = 0; i < 4; i++) store(32'h4000 + 32'(4*i), $urandom, 4'hF);
    step();
    waitrequest   = 1'b0;
    wr_valid      = 1'b1;
    wr_address    = 32'h4040;
    wr_data       = 32'hCAFE_F00D;
    wr_byteenable = 4'hF;
    #1;
    chk("t4_ready_pop0", 64'(wr_ready_o[0]), 64'(0));
    chk("t4_ready_pop1", 64'(wr_ready_o[1]), 64'(0));
    step();
    waitrequest = 1'b1;
    #1;
    chk("t4_ready_next", 64'(wr_ready_o[1]), 64'(1));
    step();
    wr_valid = 1'b0;
    #1;
    chk("t4_count", 64'(count_o[1]), 64'(DEPTH));
    drain();

    // No merge into the issuing head.
    waitrequest = 1'b1;
    store(32'h5000, 32'h1111_1111, 4'hF);
    step();
    step();
    store(32'h5000, 32'h2222_2222, 4'hF);
    #1;
    chk("t5_count", 64'(count_o[0]), 64'(2));
    drain();

    // Asynchronous reset mid-drain.
    waitrequest = 1'b1;
    for (int i = 0; i < 3; i++) store(32'h6000 + 32'(4*i), $urandom, 4'hF);
    step();
    #2 rst = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("t6_d%0d_mem_write", d), 64'(mem_write_o[d]), 64'(0));
      chk($sformatf("t6_d%0d_count", d), 64'(count_o[d]), 64'(0));
      chk($sformatf("t6_d%0d_empty", d), 64'(empty_o[d]), 64'(1));
      chk($sformatf("t6_d%0d_ready", d), 64'(wr_ready_o[d]), 64'(1));
      mq[d].delete();
      iss[d] = 1'b0;
    end
    mem_exp.delete();
    mem_act.delete();
    @(negedge clk);
    rst = 1'b1;

    // Random traffic over a small address window to exercise merging, forwarding and wrap.
    for (int c = 0; c < 1500; c++) begin
      wr_valid      = ($urandom_range(0, 99) < 60);
      wr_address    = 32'h7000 + 32'(4 * $urandom_range(0, 5)) + 32'($urandom_range(0, 3));
      wr_data       = $urandom;
      wr_byteenable = 4'($urandom_range(1, 15));
      lk_address    = 32'h7000 + 32'(4 * $urandom_range(0, 5));
      waitrequest   = ($urandom_range(0, 99) < 40);
      step();
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mips_write_buffer.md
Name: mips_write_buffer

Overview:
Parametrised posted-write buffer between the MIPS data port and the Avalon bus. It generalises the fixed write buffer in mips_cache_controller to any power-of-2 depth and adds byte-lane write merging plus per-byte store-to-load forwarding. CPU stores retire in one cycle; the buffer drains to memory in FIFO order as a standalone Avalon write master.

Parameters:
DEPTH, 4, number of entries; power of 2, minimum 2
MERGE_EN, 1, 1 = merge stores into a matching non-issued entry; 0 = strict FIFO
ADDR_W, 32, byte address width

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous, active-low reset (asserted at 0)
wr_valid  in  1  CPU store request
wr_address  in  ADDR_W  byte address; bits [1:0] ignored, stored as 0
wr_data  in  32  store data, lane-aligned
wr_byteenable  in  4  store byte lanes
wr_ready  out  1  store accepted this cycle when wr_valid=1
lk_address  in  ADDR_W  forwarding lookup address
lk_byteenable  out  4  lanes supplied by the buffer for lk_address
lk_data  out  32  forwarded lanes; uncovered lanes are 0
mem_address  out  ADDR_W  Avalon write address, word aligned
mem_write  out  1  Avalon write strobe
mem_writedata  out  32  Avalon write data
mem_byteenable  out  4  Avalon byte enable
waitrequest  in  1  Avalon slave stall
count  out  $clog2(DEPTH)+1  valid entries
empty  out  1  count==0 and no write in flight

Behaviour:
- Reset (rst=0, async): head=tail=0, all valid bits 0, mem_write=0, count=0, empty=1, wr_ready=1. Mid-drain reset aborts the bus write; this is accepted.
- Storage: circular array of {addr[ADDR_W-1:2], data, be, valid}. Head/tail pointers are $clog2(DEPTH)+1 bits; full = MSBs differ and low bits equal.
- wr_ready = !full || merge_hit (combinational). Push only when wr_valid && wr_ready.
- Merge (MERGE_EN=1): merge_hit = some valid entry, excluding the head while mem_write=1, has a word address equal to wr_address[ADDR_W-1:2].
  - On hit, the youngest matching entry takes the new byte lanes (be |= wr_byteenable, data lanes overwritten). Count is unchanged.
  - At most one non-head entry per word can exist.
- Drain: while count>0, mem_write=1 and mem_* are driven from the head entry as registered outputs.
  - Outputs stay stable while waitrequest=1.
  - When mem_write && !waitrequest, the head pops and the next entry is presented on the following cycle. This gives one bus write per 2 cycles minimum; back-to-back presentation is not required.
- Simultaneous push and pop: both take effect and count is unchanged. A push into a full buffer in the pop cycle is refused; wr_ready stays low that cycle.
- Lookup (combinational): for each lane b, take the youngest valid entry, including the issuing head, with matching word address and be[b]=1.
  - lk_byteenable[b]=1 and lk_data lane b comes from that entry.
  - A store pushed in the same cycle is not visible to lookup until the next cycle.
- Pointer wrap: pointers wrap modulo 2*DEPTH; DEPTH-1 → 0 index wrap must preserve FIFO order and youngest-wins priority.
- count/empty are registered and update the cycle after push/pop.

Decomposition:
- Package mips_wb_pkg: wb_entry_t struct {word_addr, data, be, valid} and the WB_PTR_W function of DEPTH.
- One sub-module: mips_wb_lane_select, a per-lane youngest-match priority selector. It is instantiated 4× for forwarding, and once on the word match for merging.

Test Plan:
1. Reset, then 4 stores 0x1000..0x100C (data i*i, be 1111) with waitrequest held 1 → count=4, wr_ready=0, mem_address=0x1000 stable; release waitrequest → writes appear in order, empty=1 after the 4th.
2. DEPTH=4, MERGE_EN=1, waitrequest=1: store 0x2000 be 0001 data 0x000000AA, then 0x2004, then 0x2004 be 0100 data 0x00BB0000 → second 0x2004 merges, count=2, lk_address=0x2004 gives lk_byteenable showing the merged lanes.
3. Store 0x3000 be 0101 data 0x00110022, then 0x3000 be 0011 data 0x00003344 with MERGE_EN=0 → lk_data=0x00113344, lk_byteenable=0111 (youngest wins on lane 0).
4. Fill buffer, then push while the head completes (waitrequest 1→0) → push refused that cycle, accepted next; count returns to DEPTH.
5. Store to the issuing head's address during drain → no merge into head, new entry allocated; memory ends with the later data.
6. Assert rst=0 mid-drain with count=3 → mem_write=0 immediately, count=0, empty=1 without waiting for a clock.
